spi_slave: RTL and testbench



---
 rtl/spi_slave.sv | 243 ++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI mode-0 slave (CPOL 0, CPHA 0), 8-bit frames, configurable bit order.
// All SPI pins are oversampled in the clk domain through 2-FF synchronisers;
// every action happens 3 clk cycles after the pin edge that caused it.
// Each received byte is delivered with its RES (data/command) flag. Bytes to
// return on MISO come from a one-entry holding register with valid/ready.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   spi_cs       chip select, active low (async)
//   spi_sck      serial clock, idle low (async)
//   spi_mosi     master-out data (async)
//   spi_res      data/command flag from master (async)
//   spi_miso     slave-out data (registered)
//   tx_data      byte to return on MISO
//   tx_valid     tx_data valid
//   tx_ready     holding register empty
//   rx_data      last complete received byte
//   rx_res       RES level sampled with the 8th bit of that byte
//   rx_valid     one-cycle pulse when rx_data / rx_res update
//   tx_underrun  one-cycle pulse when a byte starts with an empty holding reg
//   frame_abort  one-cycle pulse when CS rises mid-byte
//   busy         frame in progress
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | CS high (or frame ignored after reset); MISO low, SCK ignored
// ST_ACTIVE | CS low; shifting bits on SCK edges
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_res,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_res,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       frame_abort,
  output logic       busy
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Position of the first bit on the wire within a byte.
  localparam logic [2:0] FIRST_IDX = (LSB_FIRST != 0) ? 3'd0 : 3'd7;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_cs_s1, r_cs_s2, r_cs_d;
  logic        r_sck_s1, r_sck_s2, r_sck_d;
  logic        r_mosi_s1, r_mosi_s2;
  logic        r_res_s1, r_res_s2;

  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_tx_shift;
  logic [7:0]  r_tx_next;
  logic [7:0]  r_hold;
  logic        r_hold_full;

  logic        r_miso;
  logic [7:0]  r_rx_data;
  logic        r_rx_res;
  logic        r_rx_valid;
  logic        r_tx_underrun;
  logic        r_frame_abort;

  logic        w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
  logic        w_start, w_stop, w_rise, w_fall;
  logic        w_load_req;
  logic        w_push;
  logic [7:0]  w_load_byte;
  logic [2:0]  w_bit_idx;
  logic [7:0]  w_rx_byte;

  assign w_cs_fall  =  r_cs_d  & ~r_cs_s2;
  assign w_cs_rise  = ~r_cs_d  &  r_cs_s2;
  assign w_sck_rise = ~r_sck_d &  r_sck_s2;
  assign w_sck_fall =  r_sck_d & ~r_sck_s2;

  // Wire position of the current bit, mapped to a byte bit index.
  assign w_bit_idx = (LSB_FIRST != 0) ? r_bit_cnt : (3'd7 - r_bit_cnt);

  // Byte-start load: take the holding register if full, otherwise send zeros.
  assign w_load_byte = r_hold_full ? r_hold : 8'h00;
  assign w_load_req  = w_start | (w_rise & (r_bit_cnt == 3'd7));
  assign w_push      = tx_valid & ~r_hold_full;

  // The final bit comes straight from the synchroniser so rx_data is
  // complete in the same cycle as the 8th edge.
  always_comb begin
    w_rx_byte            = r_rx_shift;
    w_rx_byte[w_bit_idx] = r_mosi_s2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A CS edge takes priority over any SCK edge seen in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_start     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_stop      = 1'b1;
        end else if (w_sck_rise) begin
          w_rise = 1'b1;
        end else if (w_sck_fall) begin
          w_fall = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Synchronisers clear to 0, and so does the previous-value register,
      // so a CS pin already low at release never looks like a falling edge.
      r_cs_s1       <= 1'b0;
      r_cs_s2       <= 1'b0;
      r_cs_d        <= 1'b0;
      r_sck_s1      <= 1'b0;
      r_sck_s2      <= 1'b0;
      r_sck_d       <= 1'b0;
      r_mosi_s1     <= 1'b0;
      r_mosi_s2     <= 1'b0;
      r_res_s1      <= 1'b0;
      r_res_s2      <= 1'b0;
      r_bit_cnt     <= 3'd0;
      r_rx_shift    <= 8'h00;
      r_tx_shift    <= 8'h00;
      r_tx_next     <= 8'h00;
      r_hold        <= 8'h00;
      r_hold_full   <= 1'b0;
      r_miso        <= 1'b0;
      r_rx_data     <= 8'h00;
      r_rx_res      <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_cs_s1   <= spi_cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
      r_sck_s1  <= spi_sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_res_s1  <= spi_res;
      r_res_s2  <= r_res_s1;

      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_abort <= 1'b0;

      // Consume only happens when full and push only when empty, so the two
      // never collide; a push alongside an underrun start is kept.
      if (w_load_req) begin
        if (r_hold_full) r_hold_full   <= 1'b0;
        else             r_tx_underrun <= 1'b1;
      end
      if (w_push) begin
        r_hold_full <= 1'b1;
        r_hold      <= tx_data;
      end

      if (w_start) begin
        r_tx_shift <= w_load_byte;
        r_miso     <= w_load_byte[FIRST_IDX];
        r_bit_cnt  <= 3'd0;
      end

      if (w_stop) begin
        if (r_bit_cnt != 3'd0) r_frame_abort <= 1'b1;
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= 8'h00;
        r_miso     <= 1'b0;
      end

      if (w_rise) begin
        r_rx_shift[w_bit_idx] <= r_mosi_s2;
        r_bit_cnt             <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_data  <= w_rx_byte;
          r_rx_res   <= r_res_s2;
          r_rx_valid <= 1'b1;
          r_tx_next  <= w_load_byte;
        end
      end

      // bit_cnt == 0 on a fall means a byte just completed: switch to the
      // byte staged at the 8th rise.
      if (w_fall) begin
        if (r_bit_cnt != 3'd0) begin
          r_miso <= r_tx_shift[w_bit_idx];
        end else begin
          r_tx_shift <= r_tx_next;
          r_miso     <= r_tx_next[FIRST_IDX];
        end
      end
    end
  end

  assign spi_miso    = r_miso;
  assign tx_ready    = ~r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_res      = r_rx_res;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_tx_underrun;
  assign frame_abort = r_frame_abort;
  assign busy        = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
// Directed bench for spi_slave. u_dut0 (LSB first) is checked every cycle
// against a transaction-level model: every pin change made by the bench is
// queued as an event that takes effect 3 clk cycles later, pushes 1 cycle
// later. u_dut1 (MSB first) is checked with literal expectations only.
// ---------------------------------------------------------------------------
module tb_spi_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       cs0 = 1'b1, cs1 = 1'b1, sck = 1'b0, mosi = 1'b0, res = 1'b0;
  logic [7:0] txd0 = 8'h00, txd1 = 8'h00;
  logic       txv0 = 1'b0, txv1 = 1'b0;

  logic       miso0, tx_ready0, rx_res0, rx_valid0, und0, abt0, busy0;
  logic [7:0] rx_data0;
  logic       miso1, tx_ready1, rx_res1, rx_valid1, und1, abt1, busy1;
  logic [7:0] rx_data1;

  spi_slave #(.LSB_FIRST(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .spi_cs(cs0), .spi_sck(sck), .spi_mosi(mosi),
    .spi_res(res), .spi_miso(miso0), .tx_data(txd0), .tx_valid(txv0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_res(rx_res0),
    .rx_valid(rx_valid0), .tx_underrun(und0), .frame_abort(abt0), .busy(busy0)
  );

  spi_slave #(.LSB_FIRST(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .spi_cs(cs1), .spi_sck(sck), .spi_mosi(mosi),
    .spi_res(res), .spi_miso(miso1), .tx_data(txd1), .tx_valid(txv1),
    .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_res(rx_res1),
    .rx_valid(rx_valid1), .tx_underrun(und1), .frame_abort(abt1), .busy(busy1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // ---------------- model ----------------
  localparam int K_CSF = 0, K_CSR = 1, K_SCKR = 2, K_SCKF = 3,
                 K_PUSH = 4, K_RST = 5, K_REL = 6;

  typedef struct {
    int         due;
    int         kind;
    logic       dat;
    logic       rs;
    logic [7:0] val;
  } ev_t;

  ev_t evq[$];

  bit         m_on = 0;
  bit         m_active, m_armed, m_full;
  logic [7:0] m_hold, m_shift, m_next, m_rxs, m_rx_data;
  logic       m_rx_res, m_miso;
  int         m_bit;
  logic       m_rxv, m_und, m_abt;

  task automatic sched(input int kind, input int due, input logic dat, input logic rs, input logic [7:0] val);
    evq.push_back('{due, kind, dat, rs, val});
  endtask

  // Byte about to be sent: holding register if full, else zeros + underrun.
  function automatic logic [7:0] m_take();
    logic [7:0] b;
    if (m_full) begin
      b      = m_hold;
      m_full = 0;
    end else begin
      b     = 8'h00;
      m_und = 1'b1;
    end
    return b;
  endfunction

  function automatic void m_apply(input ev_t e);
    case (e.kind)
      K_RST: begin
        m_on = 1; m_active = 0; m_armed = 0; m_full = 0;
        m_hold = 0; m_shift = 0; m_next = 0; m_rxs = 0;
        m_rx_data = 0; m_rx_res = 0; m_miso = 0; m_bit = 0;
      end
      K_REL: m_armed = e.dat;
      K_PUSH: begin
        m_full = 1;
        m_hold = e.val;
      end
      K_CSF: if (!m_active && m_armed) begin
        m_active = 1;
        m_bit    = 0;
        m_shift  = m_take();
        m_miso   = m_shift[0];
      end
      K_CSR: begin
        m_armed = 1;
        if (m_active) begin
          if (m_bit != 0) m_abt = 1'b1;
          m_active = 0;
          m_bit    = 0;
          m_miso   = 1'b0;
        end
      end
      K_SCKR: if (m_active) begin
        m_rxs[m_bit] = e.dat;
        if (m_bit == 7) begin
          m_rx_data = m_rxs;
          m_rx_res  = e.rs;
          m_rxv     = 1'b1;
          m_next    = m_take();
          m_bit     = 0;
        end else begin
          m_bit++;
        end
      end
      K_SCKF: if (m_active) begin
        if (m_bit != 0) begin
          m_miso = m_shift[m_bit];
        end else begin
          m_shift = m_next;
          m_miso  = m_shift[0];
        end
      end
      default: ;
    endcase
  endfunction

  // ---------------- monitor / compare ----------------
  int         rxv_cnt0, und_cnt0, abt_cnt0, rxv_cnt1;
  logic [7:0] rxlog[0:7];
  int         rxn;

  initial begin
    ev_t keep[$];
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      m_rxv = 0; m_und = 0; m_abt = 0;
      keep = {};
      foreach (evq[i]) begin
        if (evq[i].due == cyc) m_apply(evq[i]);
        else keep.push_back(evq[i]);
      end
      evq = keep;
      if (m_on) begin
        chk("miso",        {7'd0, miso0},     {7'd0, m_miso});
        chk("tx_ready",    {7'd0, tx_ready0}, {7'd0, ~m_full});
        chk("rx_data",     rx_data0,          m_rx_data);
        chk("rx_res",      {7'd0, rx_res0},   {7'd0, m_rx_res});
        chk("rx_valid",    {7'd0, rx_valid0}, {7'd0, m_rxv});
        chk("tx_underrun", {7'd0, und0},      {7'd0, m_und});
        chk("frame_abort", {7'd0, abt0},      {7'd0, m_abt});
        chk("busy",        {7'd0, busy0},     {7'd0, m_active});
      end
      if (rx_valid0 === 1'b1) begin
        rxv_cnt0++;
        if (rxn < 8) rxlog[rxn] = rx_data0;
        rxn++;
      end
      if (und0 === 1'b1)      und_cnt0++;
      if (abt0 === 1'b1)      abt_cnt0++;
      if (rx_valid1 === 1'b1) rxv_cnt1++;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] rd_bits;
  logic [7:0] ser_bits;

  task automatic clr();
    rxv_cnt0 = 0; und_cnt0 = 0; abt_cnt0 = 0; rxv_cnt1 = 0; rxn = 0;
    for (int i = 0; i < 8; i++) rxlog[i] = 8'hEE;
    rd_bits  = 8'hEE;
    ser_bits = 8'hEE;
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst_n = 1'b0;
    sched(K_RST, cyc + 1, 1'b0, 1'b0, 8'h00);
    repeat (ncyc) @(negedge clk);
    rst_n = 1'b1;
    sched(K_REL, cyc + 1, cs0, 1'b0, 8'h00);
  endtask

  task automatic set_cs(input int sel, input logic v);
    @(negedge clk);
    if (sel == 0) begin
      cs0 = v;
      sched(v ? K_CSR : K_CSF, cyc + 3, 1'b0, 1'b0, 8'h00);
    end else begin
      cs1 = v;
    end
  endtask

  // Mode 0 master: MOSI set with the preceding SCK fall, MISO read just
  // before the SCK rise; half period 8 clk.
  task automatic send_bits(input int sel, input logic [7:0] b, input logic r,
                           input int from, input int to, input bit msb);
    int   idx;
    logic cur;
    for (int i = from; i < to; i++) begin
      idx  = msb ? 7 - i : i;
      mosi = b[idx];
      res  = r;
      repeat (8) @(negedge clk);
      cur          = (sel != 0) ? miso1 : miso0;
      rd_bits[idx] = cur;
      ser_bits     = {ser_bits[6:0], cur};
      sck = 1'b1;
      sched(K_SCKR, cyc + 3, b[idx], r, 8'h00);
      repeat (8) @(negedge clk);
      sck = 1'b0;
      sched(K_SCKF, cyc + 3, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic byte_frame(input int sel, input logic [7:0] b, input logic r, input bit msb);
    set_cs(sel, 1'b0);
    send_bits(sel, b, r, 0, 8, msb);
    repeat (8) @(negedge clk);
    set_cs(sel, 1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic push0(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (m_full && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL push0_timeout: tx_ready stayed low, want high within 300 cycles");
    end else begin
      txd0 = b;
      txv0 = 1'b1;
      sched(K_PUSH, cyc + 1, 1'b0, 1'b0, b);
      @(negedge clk);
      txv0 = 1'b0;
    end
  endtask

  task automatic push1(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (tx_ready1 !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL push1_timeout: tx_ready stayed low, want high within 300 cycles");
    end else begin
      txd1 = b;
      txv1 = 1'b1;
      @(negedge clk);
      txv1 = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [7:0] r1, r2;
    int         u_after1;

    clr();
    do_reset(4);
    repeat (4) @(negedge clk);
    chk("reset_tx_ready", {7'd0, tx_ready0}, 8'h01);
    chk("reset_rx_data",  rx_data0,          8'h00);
    chk("reset_busy",     {7'd0, busy0},     8'h00);

    // 1: pushed 0x3C returned while 0xA5/RES=1 received
    clr();
    push0(8'h3C);
    byte_frame(0, 8'hA5, 1'b1, 0);
    chk("t1_rxv_count", rxv_cnt0[7:0],     8'd1);
    chk("t1_rx_data",   rx_data0,          8'hA5);
    chk("t1_rx_res",    {7'd0, rx_res0},   8'h01);
    chk("t1_miso_byte", rd_bits,           8'h3C);
    chk("t1_tx_ready",  {7'd0, tx_ready0}, 8'h01);

    // 2: underrun at frame start, zeros on MISO
    clr();
    set_cs(0, 1'b0);
    repeat (6) @(negedge clk);
    chk("t2_underrun_at_start", und_cnt0[7:0], 8'd1);
    send_bits(0, 8'h00, 1'b0, 0, 8, 0);
    repeat (8) @(negedge clk);
    set_cs(0, 1'b1);
    repeat (10) @(negedge clk);
    chk("t2_miso_byte", rd_bits,         8'h00);
    chk("t2_rx_data",   rx_data0,        8'h00);
    chk("t2_rx_res",    {7'd0, rx_res0}, 8'h00);
    chk("t2_rxv_count", rxv_cnt0[7:0],   8'd1);

    // 3: two bytes in one frame, second tx byte pushed mid-frame
    clr();
    push0(8'h11);
    set_cs(0, 1'b0);
    fork
      begin
        send_bits(0, 8'h01, 1'b0, 0, 8, 0);
        r1       = rd_bits;
        u_after1 = und_cnt0;
        send_bits(0, 8'h80, 1'b0, 0, 8, 0);
        r2       = rd_bits;
      end
      push0(8'h22);
    join
    repeat (8) @(negedge clk);
    set_cs(0, 1'b1);
    repeat (10) @(negedge clk);
    chk("t3_rxv_count",   rxv_cnt0[7:0], 8'd2);
    chk("t3_rx_first",    rxlog[0],      8'h01);
    chk("t3_rx_second",   rxlog[1],      8'h80);
    chk("t3_miso_first",  r1,            8'h11);
    chk("t3_miso_second", r2,            8'h22);
    chk("t3_no_underrun", u_after1[7:0], 8'd0);

    // 4: abort after 5 bits, then a good frame
    clr();
    set_cs(0, 1'b0);
    send_bits(0, 8'hFF, 1'b1, 0, 5, 0);
    repeat (8) @(negedge clk);
    set_cs(0, 1'b1);
    repeat (6) @(negedge clk);
    chk("t4_abort_count", abt_cnt0[7:0],   8'd1);
    chk("t4_rxv_count",   rxv_cnt0[7:0],   8'd0);
    chk("t4_idle_miso",   {7'd0, miso0},   8'h00);
    chk("t4_idle_busy",   {7'd0, busy0},   8'h00);
    byte_frame(0, 8'h5A, 1'b0, 0);
    chk("t4_rx_data",     rx_data0,        8'h5A);

    // 5: reset mid-frame, rest of that frame ignored
    clr();
    set_cs(0, 1'b0);
    send_bits(0, 8'hB6, 1'b1, 0, 3, 0);
    repeat (6) @(negedge clk);
    do_reset(3);
    chk("t5_rst_rx_data",  rx_data0,          8'h00);
    chk("t5_rst_tx_ready", {7'd0, tx_ready0}, 8'h01);
    chk("t5_rst_busy",     {7'd0, busy0},     8'h00);
    chk("t5_rst_miso",     {7'd0, miso0},     8'h00);
    repeat (6) @(negedge clk);
    send_bits(0, 8'hB6, 1'b1, 3, 8, 0);
    repeat (8) @(negedge clk);
    set_cs(0, 1'b1);
    repeat (10) @(negedge clk);
    chk("t5_rxv_count",   rxv_cnt0[7:0], 8'd0);
    chk("t5_abort_count", abt_cnt0[7:0], 8'd0);
    chk("t5_rx_data",     rx_data0,      8'h00);
    byte_frame(0, 8'hC3, 1'b1, 0);
    chk("t5_next_rx_data", rx_data0,        8'hC3);
    chk("t5_next_rx_res",  {7'd0, rx_res0}, 8'h01);

    // 6: MSB-first instance
    clr();
    push1(8'h0F);
    byte_frame(1, 8'h81, 1'b0, 1);
    chk("t6_rx_data",      rx_data1,      8'h81);
    chk("t6_rxv_count",    rxv_cnt1[7:0], 8'd1);
    chk("t6_miso_byte",    rd_bits,       8'h0F);
    chk("t6_miso_order",   ser_bits,      8'b0000_1111);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
